// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU register stack: op and tag encodings, FSM states,
// and the extended-precision (80-bit) field layout.
package fpu_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_PUSH   = 3'd1,
        OP_POP    = 3'd2,
        OP_WRITE  = 3'd3,
        OP_XCHG   = 3'd4,
        OP_FREE   = 3'd5,
        OP_INCTOP = 3'd6,
        OP_DECTOP = 3'd7
    } fpu_op_e;

    typedef enum logic [1:0] {
        TAG_VALID   = 2'b00,
        TAG_ZERO    = 2'b01,
        TAG_SPECIAL = 2'b10,
        TAG_EMPTY   = 2'b11
    } fpu_tag_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_XCHG2 = 1'b1
    } fpu_state_e;

    localparam int          EXT_W     = 80;
    localparam int          SIGN_BIT  = 79;
    localparam int          EXP_MSB   = 78;
    localparam int          EXP_LSB   = 64;
    localparam int          FRAC_MSB  = 63;
    localparam int          EXP_BIAS  = 16383;
    localparam logic [14:0] EXP_MAX   = 15'h7FFF;

endpackage

// File: rtl/fpu_tag_classify.sv
// Combinational tag classifier for an extended-format value (sign bit is irrelevant
// and not taken). Used only when FPU_TAG_CLASSIFY_EN is defined.
module fpu_tag_classify
    import fpu_pkg::*;
(
    input  logic [78:0] exp_frac_i,
    output logic [1:0]  tag_o
);

    logic [14:0] exp_w;
    logic [63:0] frac_w;

    assign exp_w  = exp_frac_i[EXP_MSB:EXP_LSB];
    assign frac_w = exp_frac_i[FRAC_MSB:0];

    // exp==0 with nonzero fraction (denormal) and a clear integer bit (unnormal)
    // both land in special via the bit-63 test once the zero case is excluded.
    always_comb begin
        tag_o = TAG_VALID;
        if (exp_w == 15'd0 && frac_w == 64'd0) begin
            tag_o = TAG_ZERO;
        end else if (exp_w == EXP_MAX || exp_w == 15'd0 || !frac_w[FRAC_MSB]) begin
            tag_o = TAG_SPECIAL;
        end
    end

endmodule

// File: rtl/fpu_stack_ctrl.sv
// 8-deep x 80-bit FPU register stack with TOP pointer, tag word and SF fault reporting.
// Ops complete in one cycle (done after accept edge); XCHG takes two and drops cmd_ready for one.
// Optional FPU_TAG_CLASSIFY_EN: writes classify the value into zero/special/valid tags.
module fpu_stack_ctrl
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_idx,
    input  logic [79:0] cmd_data,
    output logic [79:0] st0_data,
    output logic [79:0] sti_data,
    output logic        st0_empty,
    output logic        sti_empty,
    output logic [2:0]  top,
    output logic [15:0] tag_word,
    output logic        done,
    output logic        fault,
    output logic        fault_c1
);

    logic [79:0] regs_q [8];
    logic [79:0] regs_d [8];
    logic [1:0]  tags_q [8];
    logic [1:0]  tags_d [8];
    logic [2:0]  top_q, top_d;
    fpu_state_e  state_q, state_d;
    logic [79:0] hold_q, hold_d;
    logic [2:0]  xidx_q, xidx_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        c1_q, c1_d;

    logic [2:0]  phys_i;
    logic [2:0]  phys_push;
    logic [1:0]  wtag;
    logic        accept;

    assign phys_i    = top_q + cmd_idx;
    assign phys_push = top_q - 3'd1;

`ifdef FPU_TAG_CLASSIFY_EN
    fpu_tag_classify u_classify (
        .exp_frac_i (cmd_data[78:0]),
        .tag_o      (wtag)
    );
`else
    assign wtag = TAG_VALID;
`endif

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    assign st0_data  = regs_q[top_q];
    assign sti_data  = regs_q[phys_i];
    assign st0_empty = (tags_q[top_q] == TAG_EMPTY);
    assign sti_empty = (tags_q[phys_i] == TAG_EMPTY);
    assign top       = top_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign fault_c1  = c1_q;

    always_comb begin
        tag_word = '0;
        for (int k = 0; k < 8; k++) begin
            tag_word[2*k +: 2] = tags_q[k];
        end
    end

    always_comb begin
        regs_d  = regs_q;
        tags_d  = tags_q;
        top_d   = top_q;
        state_d = state_q;
        hold_d  = hold_q;
        xidx_d  = xidx_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        c1_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    done_d = 1'b1;
                    case (fpu_op_e'(cmd_op))
                        OP_PUSH: begin
                            if (tags_q[phys_push] != TAG_EMPTY) begin
                                fault_d = 1'b1;
                                c1_d    = 1'b1;
                            end else begin
                                top_d             = phys_push;
                                regs_d[phys_push] = cmd_data;
                                tags_d[phys_push] = wtag;
                            end
                        end
                        OP_POP: begin
                            if (tags_q[top_q] == TAG_EMPTY) begin
                                fault_d = 1'b1;
                            end else begin
                                tags_d[top_q] = TAG_EMPTY;
                                top_d         = top_q + 3'd1;
                            end
                        end
                        OP_WRITE: begin
                            regs_d[phys_i] = cmd_data;
                            tags_d[phys_i] = wtag;
                        end
                        OP_XCHG: begin
                            if (tags_q[top_q] == TAG_EMPTY || tags_q[phys_i] == TAG_EMPTY) begin
                                fault_d = 1'b1;
                            end else if (cmd_idx != 3'd0) begin
                                // Completion is reported from XCHG2 once the swap commits.
                                done_d  = 1'b0;
                                hold_d  = regs_q[top_q];
                                xidx_d  = phys_i;
                                state_d = ST_XCHG2;
                            end
                        end
                        OP_FREE:   tags_d[phys_i] = TAG_EMPTY;
                        OP_INCTOP: top_d = top_q + 3'd1;
                        OP_DECTOP: top_d = top_q - 3'd1;
                        default: ;
                    endcase
                end
            end
            ST_XCHG2: begin
                regs_d[top_q]  = regs_q[xidx_q];
                regs_d[xidx_q] = hold_q;
                tags_d[top_q]  = tags_q[xidx_q];
                tags_d[xidx_q] = tags_q[top_q];
                done_d         = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 8; k++) begin
                regs_q[k] <= '0;
                tags_q[k] <= TAG_EMPTY;
            end
            top_q   <= 3'd0;
            state_q <= ST_IDLE;
            hold_q  <= '0;
            xidx_q  <= 3'd0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            c1_q    <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            tags_q  <= tags_d;
            top_q   <= top_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            xidx_q  <= xidx_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            c1_q    <= c1_d;
        end
    end

endmodule
